// File: rtl/lsu_byte_master_if.sv
// lsu_byte_master_if: core request/response and byte-wide memory beat signals; master = load/store unit, slave = core + memory side
interface lsu_byte_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_memrw;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  modport master (
    input  req_valid, req_memrw, req_funct3, req_addr, req_wdata, mem_rdata, mem_ready,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_re, mem_we, mem_wdata
  );
  modport slave (
    output req_valid, req_memrw, req_funct3, req_addr, req_wdata, mem_rdata, mem_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_re, mem_we, mem_wdata
  );
endinterface

// File: rtl/lsu_byte_master.sv
// lsu_byte_master: serialises RV32 LB/LH/LW/LBU/LHU/SB/SH/SW into little-endian byte beats; ports clk, rst (sync high), bus (req/resp/mem master modport)
module lsu_byte_master #(
  parameter int TIMEOUT = 16
) (
  input logic clk,
  input logic rst,
  lsu_byte_master_if.master bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_n;
  logic [31:0] addr, wdata, rdata, ext;
  logic [2:0] f3;
  logic [1:0] idx;
  logic [CW-1:0] wcnt;
  logic memrw, err, accept, bad, last, tout;
  assign accept = state == IDLE && bus.req_valid;
  assign bad = bus.req_funct3 == 3'b011 || bus.req_funct3[2:1] == 2'b11
            || (!bus.req_memrw && bus.req_funct3[2])
            || (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0])
            || (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00);
  assign last = idx == (f3[1:0] == 2'b00 ? 2'd0 : f3[1:0] == 2'b01 ? 2'd1 : 2'd3);
  assign tout = state == ACCESS && !bus.mem_ready && wcnt == CW'(TIMEOUT - 1);
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = state == IDLE ? (accept ? (bad ? RESP : ACCESS) : IDLE)
            : state == ACCESS ? ((bus.mem_ready && last) || tout ? RESP : ACCESS)
            : IDLE;
  always_ff @(posedge clk)
    if (rst) begin
      addr <= '0;
      wdata <= '0;
      rdata <= '0;
      f3 <= '0;
      idx <= '0;
      wcnt <= '0;
      memrw <= 1'b0;
      err <= 1'b0;
    end else if (accept) begin
      addr <= bus.req_addr;
      wdata <= bus.req_wdata;
      f3 <= bus.req_funct3;
      memrw <= bus.req_memrw;
      rdata <= '0;
      idx <= '0;
      wcnt <= '0;
      err <= bad;
    end else if (state == ACCESS) begin
      if (bus.mem_ready) begin
        if (memrw) rdata[8*idx +: 8] <= bus.mem_rdata;
        idx <= idx + 2'd1;
        wcnt <= '0;
      end else begin
        wcnt <= wcnt + 1'b1;
        err <= err | tout;
      end
    end
  always_comb begin
    ext = f3[1:0] == 2'b00 ? {{24{~f3[2] & rdata[7]}}, rdata[7:0]}
        : f3[1:0] == 2'b01 ? {{16{~f3[2] & rdata[15]}}, rdata[15:0]}
        : rdata;
    bus.req_ready = state == IDLE;
    bus.mem_re = state == ACCESS && memrw;
    bus.mem_we = state == ACCESS && !memrw;
    bus.mem_addr = state == ACCESS ? addr + 32'(idx) : '0;
    bus.mem_wdata = state == ACCESS ? wdata[8*idx +: 8] : '0;
    bus.resp_valid = state == RESP;
    bus.resp_err = state == RESP && err;
    bus.resp_rdata = state == RESP && memrw && !err ? ext : '0;
  end
endmodule

// File: tb/tb_lsu_byte_master.sv
// tb_lsu_byte_master: directed load/store vectors against a byte-memory and transaction model with per-cycle checking
module tb_lsu_byte_master;
  localparam int TO = 4;
  typedef struct {logic [31:0] a; logic we; logic [7:0] d;} beat_t;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  lsu_byte_master_if b();
  lsu_byte_master #(.TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(b));
  beat_t q[$];
  logic [7:0] mem [logic [31:0]];
  int checks = 0, failures = 0;
  logic busy = 1'b0, exp_err, last_err, s, rdy;
  int cyc, exp_lat, exp_n = 0, last_lat, beat;
  logic [31:0] exp_rdata, last_rdata;
  int stall_beat = 99, stall_len = 0, stall_cnt = 0;
  function automatic logic [7:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a[7:0] ^ 8'h5A);
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    s = b.mem_re | b.mem_we;
    if (!rst) begin
      chk("req_ready", 32'(b.req_ready), 32'(!busy));
      if (s) begin
        chk("one_strobe", 32'(b.mem_re & b.mem_we), 0);
        if (q.size() == 0) chk("stray_strobe", {30'd0, b.mem_re, b.mem_we}, 0);
        else begin
          chk("mem_addr", b.mem_addr, q[0].a);
          chk("mem_we", 32'(b.mem_we), 32'(q[0].we));
          if (q[0].we) chk("mem_wdata", 32'(b.mem_wdata), 32'(q[0].d));
        end
      end
      if (busy) cyc++;
      if (b.resp_valid) begin
        if (!busy) chk("stray_resp", 32'(b.resp_valid), 0);
        else begin
          chk("resp_err", 32'(b.resp_err), 32'(exp_err));
          chk("resp_rdata", b.resp_rdata, exp_rdata);
          chk("resp_latency", cyc, exp_lat);
          last_rdata = b.resp_rdata;
          last_err = b.resp_err;
          last_lat = cyc;
          busy = 1'b0;
          q.delete();
        end
      end else if (busy && cyc > exp_lat) begin
        chk("resp_late", 32'(b.resp_valid), 1);
        busy = 1'b0;
        q.delete();
      end
    end
    beat = exp_n - q.size();
    rdy = 1'b1;
    if (rst) rdy = 1'b0;
    else if (s && beat == stall_beat && stall_cnt < stall_len) begin
      rdy = 1'b0;
      stall_cnt++;
    end
    b.mem_ready = rdy;
    b.mem_rdata = b.mem_re ? rd(b.mem_addr) : 8'h00;
    if (s && rdy && q.size() > 0) begin
      if (q[0].we) mem[q[0].a] = q[0].d;
      q.delete(0);
    end
  end
  task automatic start(input logic rw, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int n;
    logic bad, tmo;
    logic [31:0] v;
    n = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
    bad = f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (!rw && f3 >= 3'd4) || (a % n != 0);
    tmo = !bad && stall_beat < n && stall_len >= TO;
    v = 0;
    for (int i = 0; i < n; i++) v = v | (32'(rd(a + 32'(i))) << (8 * i));
    exp_rdata = (bad || tmo || !rw) ? 32'd0
              : f3 == 3'd0 ? (v[7] ? v | 32'hFFFFFF00 : v)
              : f3 == 3'd1 ? (v[15] ? v | 32'hFFFF0000 : v)
              : f3 == 3'd4 ? v & 32'hFF
              : f3 == 3'd5 ? v & 32'hFFFF : v;
    exp_err = bad || tmo;
    exp_lat = bad ? 1 : tmo ? stall_beat + TO + 1 : n + 1 + (stall_beat < n ? stall_len : 0);
    stall_cnt = 0;
    b.req_valid = 1'b1;
    b.req_memrw = rw;
    b.req_funct3 = f3;
    b.req_addr = a;
    b.req_wdata = wd;
    @(posedge clk);
    #1;
    b.req_valid = 1'b0;
    b.req_addr = $urandom;
    b.req_wdata = $urandom;
    b.req_funct3 = 3'($urandom);
    b.req_memrw = 1'($urandom);
    q.delete();
    exp_n = bad ? 0 : n;
    if (!bad) for (int i = 0; i < n; i++) q.push_back('{a + 32'(i), !rw, wd[8*i +: 8]});
    cyc = 0;
    busy = 1'b1;
  endtask
  task automatic finish_req();
    for (int k = 0; k < 64 && busy; k++) begin
      @(posedge clk);
      #1;
    end
    if (busy) begin
      chk("req_done", 32'(busy), 0);
      busy = 1'b0;
    end
  endtask
  task automatic run(input logic rw, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    start(rw, f3, a, wd);
    finish_req();
  endtask
  initial begin
    b.req_valid = 1'b1;
    b.req_memrw = 1'b0;
    b.req_funct3 = 3'd2;
    b.req_addr = 32'h100;
    b.req_wdata = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    b.req_valid = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 32'(b.req_ready), 1);
    chk("rst_resp_valid", 32'(b.resp_valid), 0);
    chk("rst_strobes", {30'd0, b.mem_re, b.mem_we}, 0);
    chk("rst_mem_addr", b.mem_addr, 0);
    @(posedge clk);
    #1;
    run(1'b0, 3'd2, 32'h100, 32'hA1B2C3D4);
    chk("sw_lat", last_lat, 5);
    chk("sw_byte0", 32'(mem[32'h100]), 32'hD4);
    chk("sw_byte3", 32'(mem[32'h103]), 32'hA1);
    mem[32'h203] = 8'h80;
    run(1'b1, 3'd0, 32'h203, 0);
    chk("lb_rdata", last_rdata, 32'hFFFFFF80);
    run(1'b1, 3'd4, 32'h203, 0);
    chk("lbu_rdata", last_rdata, 32'h00000080);
    mem[32'h300] = 8'h34;
    mem[32'h301] = 8'h92;
    run(1'b1, 3'd1, 32'h300, 0);
    chk("lh_rdata", last_rdata, 32'hFFFF9234);
    run(1'b1, 3'd5, 32'h300, 0);
    chk("lhu_rdata", last_rdata, 32'h00009234);
    run(1'b1, 3'd2, 32'h100, 0);
    chk("lw_rdata", last_rdata, 32'hA1B2C3D4);
    chk("lw_lat", last_lat, 5);
    run(1'b0, 3'd0, 32'h303, 32'hFFFFFF6C);
    run(1'b1, 3'd0, 32'h303, 0);
    chk("sb_lb_rdata", last_rdata, 32'h0000006C);
    run(1'b1, 3'd2, 32'h102, 0);
    chk("mis_lw_err", 32'(last_err), 1);
    chk("mis_lw_lat", last_lat, 1);
    run(1'b0, 3'd1, 32'h101, 32'h1234);
    chk("mis_sh_err", 32'(last_err), 1);
    run(1'b1, 3'd3, 32'h100, 0);
    chk("f3_011_err", 32'(last_err), 1);
    run(1'b0, 3'd4, 32'h100, 32'h55);
    chk("sbu_err", 32'(last_err), 1);
    run(1'b1, 3'd7, 32'h100, 0);
    run(1'b1, 3'd1, 32'h301, 0);
    stall_beat = 2;
    stall_len = 3;
    run(1'b1, 3'd2, 32'h100, 0);
    chk("stall_lat", last_lat, 8);
    chk("stall_rdata", last_rdata, 32'hA1B2C3D4);
    chk("stall_cycles", stall_cnt, 3);
    stall_beat = 0;
    stall_len = 100;
    run(1'b1, 3'd2, 32'h200, 0);
    chk("tmo_err", 32'(last_err), 1);
    chk("tmo_rdata", last_rdata, 0);
    chk("tmo_lat", last_lat, 5);
    chk("tmo_held", stall_cnt, TO);
    stall_beat = 2;
    run(1'b0, 3'd2, 32'h500, 32'h11223344);
    chk("tmo_sw_lat", last_lat, 7);
    chk("tmo_sw_kept", 32'(mem[32'h501]), 32'h33);
    stall_beat = 99;
    stall_len = 0;
    start(1'b0, 3'd2, 32'h600, 32'hCAFEF00D);
    for (int k = 0; k < 16 && q.size() != 3; k++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    busy = 1'b0;
    q.delete();
    exp_n = 0;
    @(negedge clk);
    chk("rst_mid_idle", 32'(b.req_ready), 1);
    chk("rst_mid_strobe", {30'd0, b.mem_re, b.mem_we}, 0);
    repeat (3) @(posedge clk);
    #1;
    mem[32'h400] = 8'h01;
    mem[32'h401] = 8'h02;
    mem[32'h402] = 8'h03;
    mem[32'h403] = 8'h84;
    run(1'b1, 3'd2, 32'h400, 0);
    chk("post_rst_lw", last_rdata, 32'h84030201);
    run(1'b1, 3'd1, 32'hFFFFFFFE, 0);
    run(1'b0, 3'd1, 32'h700, 32'h0000BEEF);
    run(1'b1, 3'd1, 32'h700, 0);
    chk("sh_lh_rdata", last_rdata, 32'hFFFFBEEF);
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
